// File: rtl/half_adder_structural_pkg.sv
// Shared constants and the single-lane reference function for the
// structural half adder.
package half_adder_structural_pkg;

  // Default number of independent lanes.
  localparam int HA_WIDTH_DEFAULT = 1;

  // Default for the registered output stage (1 = flops present).
  localparam bit HA_REG_OUT_DEFAULT = 1'b1;

  // Behavioural single-lane half adder returning {carry, sum}.
  // Used as an independent model of the gate-level cell.
  function automatic logic [1:0] ha_ref(input logic a, input logic b);
    logic [1:0] res;
    unique case ({a, b})
      2'b00:   res = 2'b00;
      2'b01:   res = 2'b01;
      2'b10:   res = 2'b01;
      2'b11:   res = 2'b10;
      default: res = 2'bxx;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/half_adder_cell.sv
// Single-bit half adder built only from gate primitives, so X/Z on an
// input propagates exactly as the xor/and primitives define.
module half_adder_cell (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  xor g_sum   (sum,   a, b);
  and g_carry (carry, a, b);

endmodule

// File: rtl/half_adder_structural.sv
// WIDTH independent half-adder lanes with a zero-latency combinational
// output and an optional one-cycle registered copy qualified by in_valid.
module half_adder_structural
  import half_adder_structural_pkg::*;
#(
  parameter int WIDTH   = HA_WIDTH_DEFAULT,
  parameter bit REG_OUT = HA_REG_OUT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry,
  output logic [WIDTH-1:0] sum_q,
  output logic [WIDTH-1:0] carry_q,
  output logic             out_valid
);

  // One gate-level cell per lane; lanes never share a carry.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    half_adder_cell u_cell (
      .a     (a[i]),
      .b     (b[i]),
      .sum   (sum[i]),
      .carry (carry[i])
    );
  end

  if (REG_OUT) begin : g_reg
    logic [WIDTH-1:0] sum_reg_d;
    logic [WIDTH-1:0] sum_reg_q;
    logic [WIDTH-1:0] carry_reg_d;
    logic [WIDTH-1:0] carry_reg_q;
    logic             valid_reg_d;
    logic             valid_reg_q;

    // Next state: capture the lane results when in_valid, else hold them.
    always_comb begin
      sum_reg_d   = sum_reg_q;
      carry_reg_d = carry_reg_q;
      valid_reg_d = in_valid;
      if (in_valid) begin
        sum_reg_d   = sum;
        carry_reg_d = carry;
      end else begin
        sum_reg_d   = sum_reg_q;
        carry_reg_d = carry_reg_q;
      end
    end

    // Output register with asynchronous clear; reset never touches the
    // combinational lanes.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sum_reg_q   <= {WIDTH{1'b0}};
        carry_reg_q <= {WIDTH{1'b0}};
        valid_reg_q <= 1'b0;
      end else begin
        sum_reg_q   <= sum_reg_d;
        carry_reg_q <= carry_reg_d;
        valid_reg_q <= valid_reg_d;
      end
    end

    assign sum_q     = sum_reg_q;
    assign carry_q   = carry_reg_q;
    assign out_valid = valid_reg_q;
  end else begin : g_bypass
    // Without the register stage the clock and reset have no load.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;

    assign sum_q     = sum;
    assign carry_q   = carry;
    assign out_valid = in_valid;
  end

endmodule

// File: tb/tb_half_adder_structural.sv
// Directed and random checks of the structural half adder across the
// WIDTH/REG_OUT configurations, with a scoreboard on the WIDTH=8 stream.
module tb_half_adder_structural;
  import half_adder_structural_pkg::*;

  logic clk    = 1'b0;
  logic clk_en = 1'b0;
  logic rst    = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  // WIDTH=1, registered
  logic a1 = 1'b0, b1 = 1'b0, v1 = 1'b0;
  logic s1, c1, sq1, cq1, ov1;
  // WIDTH=4, registered
  logic [3:0] a4 = 4'h0, b4 = 4'h0;
  logic v4 = 1'b0;
  logic [3:0] s4, c4, sq4, cq4;
  logic ov4;
  // WIDTH=1, bypass
  logic a0 = 1'b0, b0 = 1'b0, v0 = 1'b0;
  logic s0, c0, sq0, cq0, ov0;
  // WIDTH=8, registered (random stream)
  logic [7:0] a8 = 8'h00, b8 = 8'h00;
  logic v8 = 1'b0;
  logic [7:0] s8, c8, sq8, cq8;
  logic ov8;

  // Scoreboard entries: {out_valid, carry_q, sum_q}
  logic [16:0] sb_q[$];
  logic [16:0] mon_e;

  half_adder_structural #(.WIDTH(1), .REG_OUT(1'b1)) u_w1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .in_valid(v1),
    .sum(s1), .carry(c1), .sum_q(sq1), .carry_q(cq1), .out_valid(ov1));
  half_adder_structural #(.WIDTH(4), .REG_OUT(1'b1)) u_w4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .in_valid(v4),
    .sum(s4), .carry(c4), .sum_q(sq4), .carry_q(cq4), .out_valid(ov4));
  half_adder_structural #(.WIDTH(1), .REG_OUT(1'b0)) u_w0 (
    .clk(clk), .rst(rst), .a(a0), .b(b0), .in_valid(v0),
    .sum(s0), .carry(c0), .sum_q(sq0), .carry_q(cq0), .out_valid(ov0));
  half_adder_structural #(.WIDTH(8), .REG_OUT(1'b1)) u_w8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .in_valid(v8),
    .sum(s8), .carry(c8), .sum_q(sq8), .carry_q(cq8), .out_valid(ov8));

  // Clock runs only once enabled so the combinational tests see it idle.
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one scoreboard entry is due just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      chk("reg8_valid", 32'(ov8), 32'(mon_e[16]));
      chk("reg8_carry", 32'(cq8), 32'(mon_e[15:8]));
      chk("reg8_sum",   32'(sq8), 32'(mon_e[7:0]));
    end
  end

  logic [1:0] exp_tab [4];
  logic [1:0] r;
  logic [7:0] exp_s, exp_c, hold_s, hold_c;

  initial begin
    // {carry,sum} for (a,b) = 00, 01, 10, 11
    exp_tab[0] = 2'b00;
    exp_tab[1] = 2'b01;
    exp_tab[2] = 2'b01;
    exp_tab[3] = 2'b10;

    #1;
    chk("rst_sum_q",     32'(sq1), 32'd0);
    chk("rst_carry_q",   32'(cq1), 32'd0);
    chk("rst_out_valid", 32'(ov1), 32'd0);

    // Exhaustive combinational with clock idle, plus bypass configuration.
    for (int k = 0; k < 4; k++) begin
      a1 = k[1]; b1 = k[0];
      a0 = k[1]; b0 = k[0]; v0 = k[0];
      #1;
      chk("comb1_sum",   32'(s1), 32'(exp_tab[k][0]));
      chk("comb1_carry", 32'(c1), 32'(exp_tab[k][1]));
      chk("byp_sum_q",   32'(sq0), 32'(exp_tab[k][0]));
      chk("byp_carry_q", 32'(cq0), 32'(exp_tab[k][1]));
      chk("byp_valid",   32'(ov0), 32'(k[0]));
    end
    v0 = 1'b1; #1;
    chk("byp_valid_hi", 32'(ov0), 32'd1);
    v0 = 1'b0; #1;
    chk("byp_valid_lo", 32'(ov0), 32'd0);

    // Registered latency on WIDTH=1.
    rst = 1'b0;
    clk_en = 1'b1;
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b1; v1 = 1'b1;
    @(posedge clk); #1;
    chk("lat_sum_q",   32'(sq1), 32'd0);
    chk("lat_carry_q", 32'(cq1), 32'd1);
    chk("lat_valid",   32'(ov1), 32'd1);
    @(negedge clk);
    a1 = 1'b0; b1 = 1'b1; v1 = 1'b0;
    @(posedge clk); #1;
    chk("hold_sum_q",   32'(sq1), 32'd0);
    chk("hold_carry_q", 32'(cq1), 32'd1);
    chk("hold_valid",   32'(ov1), 32'd0);
    chk("hold_comb_s",  32'(s1),  32'd1);
    chk("hold_comb_c",  32'(c1),  32'd0);

    // Asynchronous reset between edges.
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b0; v1 = 1'b1;
    @(posedge clk); #1;
    chk("pre_rst_sum_q", 32'(sq1), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_sum_q",   32'(sq1), 32'd0);
    chk("arst_carry_q", 32'(cq1), 32'd0);
    chk("arst_valid",   32'(ov1), 32'd0);
    chk("arst_comb_s",  32'(s1),  32'd1);
    chk("arst_comb_c",  32'(c1),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_sum_q", 32'(sq1), 32'd1);
    chk("post_rst_valid", 32'(ov1), 32'd1);
    @(negedge clk);
    v1 = 1'b0;

    // WIDTH=4 lane independence and one-cycle registered copy.
    a4 = 4'b1100; b4 = 4'b1010; v4 = 1'b1;
    #1;
    chk("w4_sum",        32'(s4),  32'h6);
    chk("w4_carry",      32'(c4),  32'h8);
    chk("w4_sum_q_pre",  32'(sq4), 32'h0);
    @(posedge clk); #1;
    chk("w4_sum_q",      32'(sq4), 32'h6);
    chk("w4_carry_q",    32'(cq4), 32'h8);
    chk("w4_valid",      32'(ov4), 32'd1);
    @(negedge clk);
    v4 = 1'b0;

    // Random stream on WIDTH=8; registered side checked by the monitor.
    hold_s = 8'h00;
    hold_c = 8'h00;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      v8 = 1'($urandom_range(0, 1));
      exp_s = 8'h00;
      exp_c = 8'h00;
      for (int i = 0; i < 8; i++) begin
        r = ha_ref(a8[i], b8[i]);
        exp_s[i] = r[0];
        exp_c[i] = r[1];
      end
      if (v8) begin
        hold_s = exp_s;
        hold_c = exp_c;
      end
      sb_q.push_back({v8, hold_c, hold_s});
      #1;
      chk("comb8_sum",   32'(s8), 32'(exp_s));
      chk("comb8_carry", 32'(c8), 32'(exp_c));
      chk("comb8_excl",  32'(s8 & c8), 32'd0);
    end
    @(posedge clk); #3;
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
